syn_branch_predictor: RTL and testbench

//  Parametrised direct-mapped branch target buffer with per-entry saturating direction counters.

---
 rtl/syn_branch_predictor_pkg.sv | 21 ++
 rtl/syn_branch_predictor_sat_counter.sv | 20 ++
 rtl/syn_branch_predictor.sv | 116 +++++++++++
 tb/tb_syn_branch_predictor.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/syn_branch_predictor_pkg.sv
// rtl/syn_branch_predictor_pkg.sv - shared widths, counter init/threshold helpers and update ops
package syn_branch_predictor_pkg;

  localparam int unsigned ADDR_BIT_DEF = 10;
  localparam int unsigned IDX_BIT_DEF  = 4;
  localparam int unsigned CTR_BIT_DEF  = 2;
  localparam int unsigned STAT_BIT_DEF = 16;

  typedef enum logic [1:0] {
    OP_NONE,
    OP_INC,
    OP_DEC,
    OP_ALLOC
  } upd_op_e;

  // Weakly-taken value; also the threshold at which the MSB reads as "taken".
  function automatic int unsigned ctr_init_val(input int unsigned w);
    return 32'd1 << (w - 1);
  endfunction

endpackage

// File: rtl/syn_branch_predictor_sat_counter.sv
// rtl/syn_branch_predictor_sat_counter.sv - combinational saturating increment/decrement
module cmb_sat_counter #(
  parameter int unsigned W = 2
) (
  input  logic [W-1:0] val,
  input  logic         inc,
  input  logic         dec,
  output logic [W-1:0] nxt
);

  always_comb begin
    nxt = val;
    if (inc) begin
      if (val != {W{1'b1}}) nxt = val + W'(1);
    end else if (dec) begin
      if (val != '0) nxt = val - W'(1);
    end
  end

endmodule

// File: rtl/syn_branch_predictor.sv
// rtl/syn_branch_predictor.sv - direct-mapped BTB with saturating direction counters and stats
module syn_branch_predictor
  import syn_branch_predictor_pkg::*;
#(
  parameter int unsigned ADDR_BIT = ADDR_BIT_DEF,
  parameter int unsigned IDX_BIT  = IDX_BIT_DEF,
  parameter int unsigned CTR_BIT  = CTR_BIT_DEF,
  parameter int unsigned STAT_BIT = STAT_BIT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                en,
  input  logic                flush,
  input  logic [ADDR_BIT-1:0] pc,
  output logic                pred_taken,
  output logic [ADDR_BIT-1:0] pc_guessed,
  input  logic                upd_en,
  input  logic [ADDR_BIT-1:0] upd_pc,
  input  logic                upd_taken,
  input  logic [ADDR_BIT-1:0] upd_target,
  input  logic                upd_mispred,
  output logic [STAT_BIT-1:0] stat_lookups,
  output logic [STAT_BIT-1:0] stat_mispred
);

  localparam int unsigned DEPTH   = 1 << IDX_BIT;
  localparam int unsigned TAG_BIT = ADDR_BIT - IDX_BIT;
  localparam logic [CTR_BIT-1:0] CTR_INIT = CTR_BIT'(ctr_init_val(CTR_BIT));

  logic [DEPTH-1:0]    valid_q;
  logic [TAG_BIT-1:0]  tag_q [DEPTH];
  logic [ADDR_BIT-1:0] tgt_q [DEPTH];
  logic [CTR_BIT-1:0]  ctr_q [DEPTH];

  logic [IDX_BIT-1:0]  idx, upd_idx;
  logic [TAG_BIT-1:0]  upd_tag;
  logic                hit, upd_hit, accept;
  logic [CTR_BIT-1:0]  ctr_nxt;
  logic [STAT_BIT-1:0] lookups_nxt, mispred_nxt;
  upd_op_e             op;

  // Lookup sees only registered state, so a same-cycle update is never bypassed.
  assign idx        = pc[IDX_BIT-1:0];
  assign hit        = valid_q[idx] && (tag_q[idx] == pc[ADDR_BIT-1:IDX_BIT]);
  assign pred_taken = hit && ctr_q[idx][CTR_BIT-1];
  assign pc_guessed = pred_taken ? tgt_q[idx] : pc + ADDR_BIT'(1);

  assign upd_idx = upd_pc[IDX_BIT-1:0];
  assign upd_tag = upd_pc[ADDR_BIT-1:IDX_BIT];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);
  assign accept  = en && upd_en && !flush;

  always_comb begin
    op = OP_NONE;
    if (accept) begin
      if (upd_hit)        op = upd_taken ? OP_INC : OP_DEC;
      else if (upd_taken) op = OP_ALLOC;
    end
  end

  cmb_sat_counter #(.W(CTR_BIT)) u_dir_ctr (
    .val (ctr_q[upd_idx]),
    .inc (op == OP_INC),
    .dec (op == OP_DEC),
    .nxt (ctr_nxt)
  );

  cmb_sat_counter #(.W(STAT_BIT)) u_stat_lookups (
    .val (stat_lookups),
    .inc (accept),
    .dec (1'b0),
    .nxt (lookups_nxt)
  );

  cmb_sat_counter #(.W(STAT_BIT)) u_stat_mispred (
    .val (stat_mispred),
    .inc (accept && upd_mispred),
    .dec (1'b0),
    .nxt (mispred_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= '0;
      stat_lookups <= '0;
      stat_mispred <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        tag_q[i] <= '0;
        tgt_q[i] <= '0;
        ctr_q[i] <= '0;
      end
    end else if (en) begin
      stat_lookups <= lookups_nxt;
      stat_mispred <= mispred_nxt;
      if (flush) begin
        valid_q <= '0;
      end else begin
        case (op)
          OP_INC: begin
            ctr_q[upd_idx] <= ctr_nxt;
            tgt_q[upd_idx] <= upd_target;
          end
          OP_DEC: ctr_q[upd_idx] <= ctr_nxt;
          OP_ALLOC: begin
            valid_q[upd_idx] <= 1'b1;
            tag_q[upd_idx]   <= upd_tag;
            tgt_q[upd_idx]   <= upd_target;
            ctr_q[upd_idx]   <= CTR_INIT;
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_syn_branch_predictor.sv
// tb/tb_syn_branch_predictor.sv - vector table plus scoreboard bench for syn_branch_predictor
module tb_syn_branch_predictor;

  localparam int AB = 10;
  localparam int SB = 4;

  logic          clk = 1'b0;
  logic          rst_n, en, flush, upd_en, upd_taken, upd_mispred;
  logic [AB-1:0] pc, upd_pc, upd_target, pc_guessed;
  logic          pred_taken;
  logic [SB-1:0] stat_lookups, stat_mispred;

  syn_branch_predictor #(.ADDR_BIT(AB), .IDX_BIT(4), .CTR_BIT(2), .STAT_BIT(SB)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .en           (en),
    .flush        (flush),
    .pc           (pc),
    .pred_taken   (pred_taken),
    .pc_guessed   (pc_guessed),
    .upd_en       (upd_en),
    .upd_pc       (upd_pc),
    .upd_taken    (upd_taken),
    .upd_target   (upd_target),
    .upd_mispred  (upd_mispred),
    .stat_lookups (stat_lookups),
    .stat_mispred (stat_mispred)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          en, flush;
    logic [AB-1:0] pc;
    logic          upd_en;
    logic [AB-1:0] upd_pc;
    logic          upd_taken;
    logic [AB-1:0] upd_target;
    logic          upd_mispred;
    logic          exp_taken;
    logic [AB-1:0] exp_guess;
    logic [SB-1:0] exp_lookups, exp_mispred;
  } vec_t;

  typedef struct {
    int            id;
    logic          taken;
    logic [AB-1:0] guess;
    logic [SB-1:0] lookups, mispred;
  } exp_t;

  vec_t vecs[$];
  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_id = 0;

  function automatic vec_t mk(input logic e, input logic f, input logic [AB-1:0] p,
                              input logic ue, input logic [AB-1:0] up, input logic ut,
                              input logic [AB-1:0] tg, input logic um, input logic xt,
                              input logic [AB-1:0] xg, input logic [SB-1:0] xl,
                              input logic [SB-1:0] xm);
    vec_t v;
    v.en = e; v.flush = f; v.pc = p; v.upd_en = ue; v.upd_pc = up; v.upd_taken = ut;
    v.upd_target = tg; v.upd_mispred = um; v.exp_taken = xt; v.exp_guess = xg;
    v.exp_lookups = xl; v.exp_mispred = xm;
    return v;
  endfunction

  task automatic check(input string name, input int id, input logic [31:0] act,
                       input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errors++;
      $display("FAIL %s step %0d got %0h want %0h", name, id, act, want);
    end
  endtask

  task automatic compare_out();
    exp_t e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $display("FAIL scoreboard_empty step %0d got 0 want 1", vec_id);
      return;
    end
    e = exp_q.pop_front();
    check("pred_taken", e.id, 32'(pred_taken), 32'(e.taken));
    check("pc_guessed", e.id, 32'(pc_guessed), 32'(e.guess));
    check("stat_lookups", e.id, 32'(stat_lookups), 32'(e.lookups));
    check("stat_mispred", e.id, 32'(stat_mispred), 32'(e.mispred));
  endtask

  task automatic apply(input vec_t v);
    exp_t e;
    @(negedge clk);
    en = v.en; flush = v.flush; pc = v.pc; upd_en = v.upd_en; upd_pc = v.upd_pc;
    upd_taken = v.upd_taken; upd_target = v.upd_target; upd_mispred = v.upd_mispred;
    e.id = vec_id; e.taken = v.exp_taken; e.guess = v.exp_guess;
    e.lookups = v.exp_lookups; e.mispred = v.exp_mispred;
    exp_q.push_back(e);
    #1;
    compare_out();
    vec_id++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog step %0d got timeout want finish", vec_id);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst_n = 1'b0; en = 1'b1; flush = 1'b0; pc = '0; upd_en = 1'b0; upd_pc = '0;
    upd_taken = 1'b0; upd_target = '0; upd_mispred = 1'b0;

    //             en f  pc      ue up      ut tgt     um xt guess   L   M
    vecs.push_back(mk(1, 0, 10'h004, 0, 10'h000, 0, 10'h000, 0, 0, 10'h005, 0, 0));
    vecs.push_back(mk(1, 0, 10'h014, 1, 10'h014, 1, 10'h040, 1, 0, 10'h015, 0, 0));
    vecs.push_back(mk(1, 0, 10'h014, 0, 10'h000, 0, 10'h000, 0, 1, 10'h040, 1, 1));
    vecs.push_back(mk(1, 0, 10'h014, 1, 10'h014, 1, 10'h040, 0, 1, 10'h040, 1, 1));
    vecs.push_back(mk(1, 0, 10'h014, 1, 10'h014, 1, 10'h040, 0, 1, 10'h040, 2, 1));
    vecs.push_back(mk(1, 0, 10'h014, 1, 10'h014, 1, 10'h041, 0, 1, 10'h040, 3, 1));
    vecs.push_back(mk(1, 0, 10'h014, 1, 10'h014, 0, 10'h000, 1, 1, 10'h041, 4, 1));
    vecs.push_back(mk(1, 0, 10'h014, 1, 10'h014, 0, 10'h000, 0, 1, 10'h041, 5, 2));
    vecs.push_back(mk(1, 0, 10'h014, 0, 10'h000, 0, 10'h000, 0, 0, 10'h015, 6, 2));
    vecs.push_back(mk(1, 0, 10'h024, 1, 10'h024, 1, 10'h080, 0, 0, 10'h025, 6, 2));
    vecs.push_back(mk(1, 0, 10'h024, 0, 10'h000, 0, 10'h000, 0, 1, 10'h080, 7, 2));
    vecs.push_back(mk(1, 0, 10'h014, 0, 10'h000, 0, 10'h000, 0, 0, 10'h015, 7, 2));
    vecs.push_back(mk(1, 0, 10'h033, 1, 10'h033, 0, 10'h000, 0, 0, 10'h034, 7, 2));
    vecs.push_back(mk(1, 0, 10'h033, 0, 10'h000, 0, 10'h000, 0, 0, 10'h034, 8, 2));
    vecs.push_back(mk(1, 1, 10'h024, 1, 10'h055, 1, 10'h011, 1, 1, 10'h080, 8, 2));
    vecs.push_back(mk(1, 0, 10'h024, 0, 10'h000, 0, 10'h000, 0, 0, 10'h025, 8, 2));
    vecs.push_back(mk(1, 0, 10'h055, 0, 10'h000, 0, 10'h000, 0, 0, 10'h056, 8, 2));
    vecs.push_back(mk(1, 0, 10'h3FF, 0, 10'h000, 0, 10'h000, 0, 0, 10'h000, 8, 2));
    vecs.push_back(mk(0, 0, 10'h014, 1, 10'h014, 1, 10'h100, 1, 0, 10'h015, 8, 2));
    vecs.push_back(mk(1, 0, 10'h014, 0, 10'h000, 0, 10'h000, 0, 0, 10'h015, 8, 2));
    vecs.push_back(mk(1, 0, 10'h000, 1, 10'h014, 1, 10'h100, 0, 0, 10'h001, 8, 2));
    vecs.push_back(mk(0, 1, 10'h014, 0, 10'h000, 0, 10'h000, 0, 1, 10'h100, 9, 2));
    vecs.push_back(mk(1, 0, 10'h014, 0, 10'h000, 0, 10'h000, 0, 1, 10'h100, 9, 2));

    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) apply(vecs[i]);

    // Stats saturate at 4'hF; the entry at 0x3A0 is allocated then climbs to strongly taken.
    for (int i = 0; i < 20; i++) begin
      int l, m;
      l = (9 + i > 15) ? 15 : 9 + i;
      m = (2 + i > 15) ? 15 : 2 + i;
      apply(mk(1, 0, 10'h3A0, 1, 10'h3A0, 1, 10'h2AA, 1, (i != 0),
               (i != 0) ? 10'h2AA : 10'h3A1, SB'(l), SB'(m)));
    end
    apply(mk(1, 0, 10'h3A0, 0, 10'h000, 0, 10'h000, 0, 1, 10'h2AA, 4'hF, 4'hF));

    // Counter floor at zero: 10 -> 01 -> 00 -> 00, then one taken gives 01 (still not taken).
    apply(mk(1, 0, 10'h014, 1, 10'h014, 0, 10'h000, 0, 1, 10'h100, 4'hF, 4'hF));
    apply(mk(1, 0, 10'h014, 1, 10'h014, 0, 10'h000, 0, 0, 10'h015, 4'hF, 4'hF));
    apply(mk(1, 0, 10'h014, 1, 10'h014, 0, 10'h000, 0, 0, 10'h015, 4'hF, 4'hF));
    apply(mk(1, 0, 10'h014, 1, 10'h014, 1, 10'h200, 0, 0, 10'h015, 4'hF, 4'hF));
    apply(mk(1, 0, 10'h014, 0, 10'h000, 0, 10'h000, 0, 0, 10'h015, 4'hF, 4'hF));

    // Reset asserted while an update is being presented: nothing survives.
    @(negedge clk);
    pc = 10'h014; upd_en = 1'b1; upd_pc = 10'h014; upd_taken = 1'b1;
    upd_target = 10'h123; upd_mispred = 1'b1;
    #2 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    upd_en = 1'b0;
    rst_n = 1'b1;
    e.id = vec_id; e.taken = 1'b0; e.guess = 10'h015; e.lookups = '0; e.mispred = '0;
    exp_q.push_back(e);
    #1;
    compare_out();
    vec_id++;
    apply(mk(1, 0, 10'h3A0, 0, 10'h000, 0, 10'h000, 0, 0, 10'h3A1, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
